// File: rtl/dio_loader_pkg.sv
// Shared types and default memory map for the data_io download loader.
package dio_loader_pkg;

    typedef enum logic [1:0] {
        TGT_ROM = 2'd0,
        TGT_DCK = 2'd1,
        TGT_TZX = 2'd2
    } targetT;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CPU  = 2'd2
    } stateT;

    localparam logic [20:0] ROM_BASE_DEF = 21'h000000;
    localparam logic [20:0] DCK_BASE_DEF = 21'h040000;
    localparam logic [20:0] TZX_BASE_DEF = 21'h100000;

endpackage

// File: rtl/dio_fifo.sv
// Synchronous FIFO for download strobes; push and pop may coincide at any fill level.
module dio_fifo #(
    parameter int FD = 4,
    parameter int W  = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [W-1:0]          din,
    output logic [W-1:0]          dout,
    output logic                  full,
    output logic                  empty,
    output logic [$clog2(FD):0]   count
);
    localparam int PW = $clog2(FD);

    logic [W-1:0]  mem [FD];
    logic [PW-1:0] wrPtr, rdPtr;
    logic          doPush, doPop;

    assign full   = (count == FD[PW:0]);
    assign empty  = (count == '0);
    assign doPop  = pop && !empty;
    // When full, a same-cycle pop frees the slot the push lands in.
    assign doPush = push && (!full || doPop);
    assign dout   = mem[rdPtr];

    always_ff @(posedge clock) begin
        if (doPush) begin
            mem[wrPtr] <= din;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            count <= count + {{PW{1'b0}}, doPush} - {{PW{1'b0}}, doPop};
        end
    end

endmodule

// File: rtl/dio_loader.sv
// Queues data_io download bytes and shares the memory port with CPU cycles.
// state | meaning
// IDLE  | port free, choosing the next grant
// LOAD  | writing the FIFO head to memory
// CPU   | serving one CPU memory cycle
module dio_loader
    import dio_loader_pkg::*;
#(
    parameter int AW = 21,
    parameter int FD = 4,
    parameter logic [AW-1:0] ROM_BASE = AW'(ROM_BASE_DEF),
    parameter logic [AW-1:0] DCK_BASE = AW'(DCK_BASE_DEF),
    parameter logic [AW-1:0] TZX_BASE = AW'(TZX_BASE_DEF)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          romE,
    input  logic          dckE,
    input  logic          tzxE,
    input  logic [26:0]   dioA,
    input  logic [7:0]    dioD,
    input  logic          dioW,
    input  logic          cpuReq,
    input  logic          cpuWe,
    input  logic [AW-1:0] cpuA,
    input  logic [7:0]    cpuD,
    output logic          cpuAck,
    output logic          memReq,
    output logic          memWe,
    output logic [AW-1:0] memA,
    output logic [7:0]    memD,
    input  logic          memAck,
    output logic          busy,
    output logic [26:0]   tzxSize,
    output logic          dckDone,
    output logic          ovf
);
    localparam int PW   = $clog2(FD);
    localparam int CW   = PW + 1;
    localparam int EW   = 2 + AW + 8;
    localparam int HALF = FD / 2;

    stateT          state, stateNext;
    targetT         pushTgt, headTgt;
    logic [EW-1:0]  pushEntry, head;
    logic [CW-1:0]  fifoCount, romCnt, romCntNext, dckCnt, dckCntNext;
    logic           fifoFull, fifoEmpty, pushOk, pushAcc, pop, cpuGo;
    logic           romPush, romPop, dckPush, dckPop;
    logic [AW-1:0]  headBase, headAddr, memANext;
    logic [7:0]     memDNext;
    logic           memReqNext, memWeNext, cpuAckNext;
    logic           romEPrev, tzxEPrev, dckArmed;
    logic [26:0]    tzxBase, tzxEnd;

    always_comb begin
        pushTgt = TGT_TZX;
        if (romE)      pushTgt = TGT_ROM;
        else if (dckE) pushTgt = TGT_DCK;
    end

    assign pushOk    = dioW && $onehot({romE, dckE, tzxE});
    assign pushAcc   = pushOk && (!fifoFull || pop);
    assign pushEntry = {pushTgt, dioA[AW-1:0], dioD};

    dio_fifo #(.FD(FD), .W(EW)) uFifo (
        .clock (clock),
        .reset (reset),
        .push  (pushOk),
        .pop   (pop),
        .din   (pushEntry),
        .dout  (head),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .count (fifoCount)
    );

    assign headTgt  = targetT'(head[EW-1 -: 2]);
    assign headAddr = head[8 +: AW];

    always_comb begin
        case (headTgt)
            TGT_DCK: headBase = DCK_BASE;
            TGT_TZX: headBase = TZX_BASE;
            default: headBase = ROM_BASE;
        endcase
    end

    // cpuAck high means cpuReq is still the request just served, not a new one.
    assign cpuGo = cpuReq && !busy && !cpuAck;

    always_comb begin
        stateNext  = state;
        memReqNext = memReq;
        memWeNext  = memWe;
        memANext   = memA;
        memDNext   = memD;
        cpuAckNext = 1'b0;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (int'(fifoCount) >= HALF || (!cpuGo && !fifoEmpty)) begin
                    stateNext  = LOAD;
                    memReqNext = 1'b1;
                    memWeNext  = 1'b1;
                    memANext   = headBase + headAddr;
                    memDNext   = head[7:0];
                end else if (cpuGo) begin
                    stateNext  = CPU;
                    memReqNext = 1'b1;
                    memWeNext  = cpuWe;
                    memANext   = cpuA;
                    memDNext   = cpuD;
                end
            end
            LOAD: begin
                if (memAck) begin
                    pop        = 1'b1;
                    memReqNext = 1'b0;
                    memWeNext  = 1'b0;
                    stateNext  = IDLE;
                end
            end
            CPU: begin
                if (memAck) begin
                    cpuAckNext = 1'b1;
                    memReqNext = 1'b0;
                    memWeNext  = 1'b0;
                    stateNext  = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            memReq <= 1'b0;
            memWe  <= 1'b0;
            memA   <= '0;
            memD   <= '0;
            cpuAck <= 1'b0;
        end else begin
            state  <= stateNext;
            memReq <= memReqNext;
            memWe  <= memWeNext;
            memA   <= memANext;
            memD   <= memDNext;
            cpuAck <= cpuAckNext;
        end
    end

    assign romPush    = pushAcc && (pushTgt == TGT_ROM);
    assign romPop     = pop && (headTgt == TGT_ROM);
    assign dckPush    = pushAcc && (pushTgt == TGT_DCK);
    assign dckPop     = pop && (headTgt == TGT_DCK);
    assign romCntNext = romCnt + CW'(romPush) - CW'(romPop);
    assign dckCntNext = dckCnt + CW'(dckPush) - CW'(dckPop);
    assign tzxBase    = (tzxE && !tzxEPrev) ? '0 : tzxSize;
    assign tzxEnd     = dioA + 27'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            romEPrev <= 1'b0;
            tzxEPrev <= 1'b0;
            romCnt   <= '0;
            dckCnt   <= '0;
            busy     <= 1'b0;
            ovf      <= 1'b0;
            tzxSize  <= '0;
            dckArmed <= 1'b0;
            dckDone  <= 1'b0;
        end else begin
            romEPrev <= romE;
            tzxEPrev <= tzxE;
            romCnt   <= romCntNext;
            dckCnt   <= dckCntNext;
            if (romE && !romEPrev)
                busy <= 1'b1;
            else if (!romE && romCntNext == '0)
                busy <= 1'b0;
            if (pushOk && fifoFull && !pop)
                ovf <= 1'b1;
            if (pushAcc && pushTgt == TGT_TZX && tzxEnd > tzxBase)
                tzxSize <= tzxEnd;
            else
                tzxSize <= tzxBase;
            dckDone <= 1'b0;
            if (dckE) begin
                dckArmed <= 1'b1;
            end else if (dckArmed && dckCntNext == '0) begin
                dckDone  <= 1'b1;
                dckArmed <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dio_loader.sv
// Directed bench for dio_loader: memory responder, transaction log and hand-computed expectations.
module tb_dio_loader;
    localparam int AW = 21;

    logic          clock = 1'b0;
    logic          reset, romE, dckE, tzxE, dioW, cpuReq, cpuWe;
    logic [26:0]   dioA;
    logic [7:0]    dioD, cpuD;
    logic [AW-1:0] cpuA;
    logic          cpuAck, memReq, memWe, memAck, busy, dckDone, ovf;
    logic [AW-1:0] memA;
    logic [7:0]    memD;
    logic [26:0]   tzxSize;

    logic respAck = 1'b0, lateAck = 1'b0, ackEn = 1'b0, reqSeen = 1'b0;
    int   checks = 0, errors = 0;
    int   ackTotal = 0, cpuAckCnt = 0, cpuAckBusy = 0, dckDoneCnt = 0, dckDoneAt = -1;
    int   base, cpuBase, dckBase;

    bit            logWe[$];
    bit            logBusy[$];
    bit [AW-1:0]   logA[$];
    bit [7:0]      logD[$];

    always #5 clock = ~clock;
    assign memAck = respAck | lateAck;

    dio_loader dut (
        .clock   (clock),
        .reset   (reset),
        .romE    (romE),
        .dckE    (dckE),
        .tzxE    (tzxE),
        .dioA    (dioA),
        .dioD    (dioD),
        .dioW    (dioW),
        .cpuReq  (cpuReq),
        .cpuWe   (cpuWe),
        .cpuA    (cpuA),
        .cpuD    (cpuD),
        .cpuAck  (cpuAck),
        .memReq  (memReq),
        .memWe   (memWe),
        .memA    (memA),
        .memD    (memD),
        .memAck  (memAck),
        .busy    (busy),
        .tzxSize (tzxSize),
        .dckDone (dckDone),
        .ovf     (ovf)
    );

    // Memory model: acknowledges one cycle after memReq rises and logs the granted access.
    initial forever begin
        @(negedge clock);
        if (cpuAck) begin
            cpuAckCnt++;
            if (busy) cpuAckBusy++;
        end
        if (dckDone) begin
            dckDoneCnt++;
            dckDoneAt = ackTotal;
        end
        if (ackEn && memReq && reqSeen && !respAck) begin
            respAck = 1'b1;
            ackTotal++;
            logWe.push_back(memWe);
            logBusy.push_back(busy);
            logA.push_back(memA);
            logD.push_back(memD);
        end else begin
            respAck = 1'b0;
        end
        reqSeen = memReq;
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic dioWrite(input logic [26:0] a, input logic [7:0] d);
        dioA = a;
        dioD = d;
        dioW = 1'b1;
        tick();
        dioW = 1'b0;
    endtask

    task automatic waitAcks(input int target, input string tag);
        for (int i = 0; i < 300 && ackTotal < target; i++) tick();
        checkVal(tag, 32'(ackTotal), 32'(target));
    endtask

    task automatic clearLog();
        logWe.delete();
        logBusy.delete();
        logA.delete();
        logD.delete();
    endtask

    initial begin
        reset = 1'b1; romE = 1'b0; dckE = 1'b0; tzxE = 1'b0; dioW = 1'b0;
        dioA = '0; dioD = '0; cpuReq = 1'b0; cpuWe = 1'b0; cpuA = '0; cpuD = '0;
        repeat (3) tick();
        checkVal("rst_flags", 32'({memReq, memWe, cpuAck, busy, dckDone, ovf}), 0);
        checkVal("rst_memA", 32'(memA), 0);
        checkVal("rst_memD", 32'(memD), 0);
        checkVal("rst_tzxSize", 32'(tzxSize), 0);
        reset = 1'b0;
        tick();

        // ROM load with a CPU request waiting behind busy
        ackEn = 1'b1;
        romE = 1'b1;
        tick();
        checkVal("rom_busy_set", 32'(busy), 1);
        cpuReq = 1'b1; cpuWe = 1'b0; cpuA = 21'h01234; cpuD = 8'h00;
        for (int i = 0; i < 8; i++) begin
            dioWrite(27'(i), 8'(8'hA0 + i));
            if (i == 7) romE = 1'b0;
            else repeat (3) tick();
        end
        waitAcks(8, "rom_acks");
        checkVal("rom_busy_fall", 32'(busy), 0);
        for (int i = 0; i < 40 && !cpuAck; i++) tick();
        checkVal("rom_cpu_served", 32'(cpuAck), 1);
        cpuReq = 1'b0;
        tick();
        checkVal("rom_no_cpuack_busy", 32'(cpuAckBusy), 0);
        checkVal("rom_log_size", 32'(logA.size()), 9);
        if (logA.size() == 9) begin
            for (int i = 0; i < 8; i++) begin
                checkVal($sformatf("rom_a%0d", i), 32'(logA[i]), 32'(i));
                checkVal($sformatf("rom_d%0d", i), 32'(logD[i]), 32'(8'hA0 + i));
                checkVal($sformatf("rom_webusy%0d", i), 32'({logWe[i], logBusy[i]}), 3);
            end
            checkVal("rom_cpu_we", 32'(logWe[8]), 0);
            checkVal("rom_cpu_a", 32'(logA[8]), 32'h01234);
        end

        // Arbitration: CPU first, then DCK once two entries are queued
        clearLog();
        base = ackTotal;
        cpuReq = 1'b1; cpuWe = 1'b1; cpuA = 21'h00ABC; cpuD = 8'h5A; dckE = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            dioA = 27'(i);
            dioD = 8'(8'h10 + i);
            dioW = 1'b1;
            tick();
            if (cpuAck) cpuReq = 1'b0;
        end
        dioW = 1'b0;
        cpuReq = 1'b0;
        waitAcks(base + 5, "arb_acks");
        checkVal("arb_log_size", 32'(logA.size()), 5);
        if (logA.size() == 5) begin
            checkVal("arb_cpu_first", 32'({logWe[0], logA[0], logD[0]}), 32'({1'b1, 21'h00ABC, 8'h5A}));
            for (int i = 1; i < 5; i++) begin
                checkVal($sformatf("arb_dck_a%0d", i), 32'(logA[i]), 32'(32'h040000 + i - 1));
                checkVal($sformatf("arb_dck_d%0d", i), 32'(logD[i]), 32'(8'h10 + i - 1));
            end
        end

        // DCK completion with two entries still queued when dckE falls
        clearLog();
        base = ackTotal;
        dckBase = dckDoneCnt;
        ackEn = 1'b0;
        dioWrite(27'd4, 8'h20);
        dioWrite(27'd5, 8'h21);
        dckE = 1'b0;
        repeat (6) tick();
        checkVal("dck_no_early", 32'(dckDoneCnt - dckBase), 0);
        ackEn = 1'b1;
        waitAcks(base + 2, "dck_acks");
        repeat (4) tick();
        checkVal("dck_pulse_once", 32'(dckDoneCnt - dckBase), 1);
        checkVal("dck_after_2nd", 32'(dckDoneAt), 32'(base + 2));
        if (logA.size() > 0) checkVal("dck_a4", 32'(logA[0]), 32'h040004);

        // Overflow: memAck held off, five strobes into a four-entry FIFO
        clearLog();
        base = ackTotal;
        ackEn = 1'b0;
        tzxE = 1'b1;
        for (int i = 0; i < 5; i++) begin
            dioWrite(27'(i), 8'(8'h30 + i));
            if (i == 3) checkVal("ovf_not_yet", 32'(ovf), 0);
        end
        checkVal("ovf_set", 32'(ovf), 1);
        ackEn = 1'b1;
        waitAcks(base + 4, "ovf_acks");
        repeat (10) tick();
        checkVal("ovf_writes", 32'(logA.size()), 4);
        if (logA.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                checkVal($sformatf("ovf_a%0d", i), 32'(logA[i]), 32'(32'h100000 + i));
                checkVal($sformatf("ovf_d%0d", i), 32'(logD[i]), 32'(8'h30 + i));
            end
        end
        checkVal("ovf_tzx_accepted", 32'(tzxSize), 4);
        checkVal("ovf_sticky", 32'(ovf), 1);

        // TZX size tracking
        tzxE = 1'b0; tick();
        tzxE = 1'b1; tick();
        checkVal("tzx_clear1", 32'(tzxSize), 0);
        clearLog();
        base = ackTotal;
        for (int i = 0; i < 100; i++) begin
            dioWrite(27'(i), 8'(i));
            repeat (3) tick();
        end
        dioWrite(27'd50, 8'hEE);
        waitAcks(base + 101, "tzx_acks");
        checkVal("tzx_size100", 32'(tzxSize), 100);
        if (logA.size() > 0) checkVal("tzx_first_a", 32'(logA[0]), 32'h100000);
        tzxE = 1'b0; tick();
        tzxE = 1'b1; tick();
        checkVal("tzx_clear2", 32'(tzxSize), 0);
        for (int i = 0; i < 10; i++) begin
            dioWrite(27'(i), 8'(i));
            repeat (3) tick();
        end
        checkVal("tzx_size10", 32'(tzxSize), 10);
        checkVal("ovf_still_set", 32'(ovf), 1);

        // Reset in the middle of a ROM load, then a stray memAck
        clearLog();
        ackEn = 1'b0;
        tzxE = 1'b0;
        romE = 1'b1;
        tick();
        dioWrite(27'd3, 8'h77);
        for (int i = 0; i < 10 && !memReq; i++) tick();
        checkVal("mid_memReq", 32'(memReq), 1);
        checkVal("mid_busy", 32'(busy), 1);
        cpuBase = cpuAckCnt;
        reset = 1'b1;
        romE = 1'b0;
        tick();
        reset = 1'b0;
        checkVal("mid_req_drop", 32'(memReq), 0);
        checkVal("mid_busy_clr", 32'(busy), 0);
        checkVal("mid_tzx_clr", 32'(tzxSize), 0);
        checkVal("mid_ovf_clr", 32'(ovf), 0);
        lateAck = 1'b1;
        tick();
        lateAck = 1'b0;
        ackEn = 1'b1;
        repeat (8) tick();
        checkVal("late_no_cpuack", 32'(cpuAckCnt - cpuBase), 0);
        checkVal("late_fifo_empty", 32'(logA.size()), 0);
        base = ackTotal;
        tzxE = 1'b1;
        dioWrite(27'd7, 8'h99);
        waitAcks(base + 1, "post_rst_ack");
        repeat (3) tick();
        checkVal("post_rst_count", 32'(logA.size()), 1);
        if (logA.size() > 0) begin
            checkVal("post_rst_a", 32'(logA[0]), 32'h100007);
            checkVal("post_rst_d", 32'(logD[0]), 32'h99);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
